onehot_slot_tracker: RTL

//  Parametrised, registered successor to the fixed 3-to-8 binary decoder.

---
 rtl/onehot_slot_tracker_if.sv | 33 +++
 rtl/onehot_slot_tracker.sv | 112 +++++++++++
 2 files changed

// File: rtl/onehot_slot_tracker_if.sv
// Handshake bundle for onehot_slot_tracker: set/clear requests in, slot state out.
interface onehot_slot_tracker_if #(
    parameter int IDX_WIDTH = 3
);
    localparam int SLOTS = 1 << IDX_WIDTH;

    logic                 set_en;
    logic [IDX_WIDTH-1:0] set_idx;
    logic                 clr_en;
    logic [IDX_WIDTH-1:0] clr_idx;
    logic [SLOTS-1:0]     dec_out;
    logic                 dec_valid;
    logic [SLOTS-1:0]     busy_mask;
    logic [IDX_WIDTH:0]   busy_count;
    logic                 full;
    logic                 empty;
    logic [IDX_WIDTH-1:0] free_idx;
    logic                 free_valid;
    logic                 err_set_busy;
    logic                 err_clr_idle;

    modport master (
        output set_en, set_idx, clr_en, clr_idx,
        input  dec_out, dec_valid, busy_mask, busy_count, full, empty,
               free_idx, free_valid, err_set_busy, err_clr_idle
    );

    modport slave (
        input  set_en, set_idx, clr_en, clr_idx,
        output dec_out, dec_valid, busy_mask, busy_count, full, empty,
               free_idx, free_valid, err_set_busy, err_clr_idle
    );
endinterface

// File: rtl/onehot_slot_tracker.sv
// Registered slot allocator: decodes set/clear indices into a busy bitmap and
// reports occupancy, full/empty and the lowest free slot, one cycle after input.
module onehot_slot_tracker #(
    parameter int IDX_WIDTH = 3,
    parameter bit THERMO    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    onehot_slot_tracker_if.slave  bus
);
    localparam int SLOTS = 1 << IDX_WIDTH;

    logic [SLOTS-1:0]     busy_mask_q,  busy_mask_d;
    logic [IDX_WIDTH:0]   busy_count_q, busy_count_d;
    logic [SLOTS-1:0]     dec_out_q,    dec_out_d;
    logic                 dec_valid_q,  dec_valid_d;
    logic                 full_q,       full_d;
    logic                 empty_q,      empty_d;
    logic [IDX_WIDTH-1:0] free_idx_q,   free_idx_d;
    logic                 free_valid_q, free_valid_d;
    logic                 err_set_q,    err_set_d;
    logic                 err_clr_q,    err_clr_d;

    logic set_hit, clr_hit, same_idx;
    logic [SLOTS-1:0] decode;

    assign set_hit  = bus.set_en & ~busy_mask_q[bus.set_idx];
    assign clr_hit  = bus.clr_en &  busy_mask_q[bus.clr_idx];
    assign same_idx = bus.set_en & bus.clr_en & (bus.set_idx == bus.clr_idx);

    always_comb begin
        decode = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (THERMO) decode[i] = (IDX_WIDTH'(i) <= bus.set_idx);
            else        decode[i] = (IDX_WIDTH'(i) == bus.set_idx);
        end
    end

    always_comb begin
        busy_mask_d = busy_mask_q;
        dec_out_d   = dec_out_q;
        dec_valid_d = 1'b0;
        err_set_d   = 1'b0;
        err_clr_d   = 1'b0;
        if (same_idx) begin
            // Same-slot set+clear is a re-allocation: the slot ends up busy.
            busy_mask_d[bus.set_idx] = 1'b1;
            dec_out_d   = decode;
            dec_valid_d = 1'b1;
            err_clr_d   = ~busy_mask_q[bus.clr_idx];
        end else begin
            if (set_hit) begin
                busy_mask_d[bus.set_idx] = 1'b1;
                dec_out_d   = decode;
                dec_valid_d = 1'b1;
            end
            if (clr_hit) busy_mask_d[bus.clr_idx] = 1'b0;
            err_set_d = bus.set_en & ~set_hit;
            err_clr_d = bus.clr_en & ~clr_hit;
        end
    end

    always_comb begin
        busy_count_d = '0;
        for (int i = 0; i < SLOTS; i++)
            busy_count_d = busy_count_d + (IDX_WIDTH+1)'(busy_mask_d[i]);
        full_d  = (busy_count_d == (IDX_WIDTH+1)'(SLOTS));
        empty_d = (busy_count_d == '0);
        free_idx_d   = '0;
        free_valid_d = ~&busy_mask_d;
        // Scan from the top so the lowest idle index wins.
        for (int i = SLOTS - 1; i >= 0; i--)
            if (!busy_mask_d[i]) free_idx_d = IDX_WIDTH'(i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_mask_q  <= '0;
            busy_count_q <= '0;
            dec_out_q    <= '0;
            dec_valid_q  <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            free_idx_q   <= '0;
            free_valid_q <= 1'b1;
            err_set_q    <= 1'b0;
            err_clr_q    <= 1'b0;
        end else begin
            busy_mask_q  <= busy_mask_d;
            busy_count_q <= busy_count_d;
            dec_out_q    <= dec_out_d;
            dec_valid_q  <= dec_valid_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            free_idx_q   <= free_idx_d;
            free_valid_q <= free_valid_d;
            err_set_q    <= err_set_d;
            err_clr_q    <= err_clr_d;
        end
    end

    assign bus.busy_mask    = busy_mask_q;
    assign bus.busy_count   = busy_count_q;
    assign bus.dec_out      = dec_out_q;
    assign bus.dec_valid    = dec_valid_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.free_idx     = free_idx_q;
    assign bus.free_valid   = free_valid_q;
    assign bus.err_set_busy = err_set_q;
    assign bus.err_clr_idle = err_clr_q;
endmodule
